// File: rtl/restoring_divider_pkg.sv
// Shared definitions for the restoring divider: FSM state encoding and
// the quotient value reported on divide-by-zero.
package restoring_divider_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Widest operand supported; the all-ones quotient is sliced to width w.
    localparam int MAX_W = 64;
    localparam logic [MAX_W-1:0] DBZ_QUOTIENT_ALL = {MAX_W{1'b1}};

endpackage

// File: rtl/restoring_divider_addsub.sv
// Ripple adder/subtractor built from full-adder cells (FAC).
// sub=1 gives a - b in two's complement; the final carry-out is not produced.
module fac (
    input  logic i_a,
    input  logic i_b,
    input  logic i_cin,
    output logic o_s,
    output logic o_cout
);
    assign o_s    = i_a ^ i_b ^ i_cin;
    assign o_cout = (i_a & i_b) | (i_a & i_cin) | (i_b & i_cin);
endmodule

module adder_subtractor #(
    parameter int w = 9
) (
    input  logic [w-1:0] i_a,
    input  logic [w-1:0] i_b,
    input  logic         i_sub,
    output logic [w-1:0] o_s
);
    logic [w-1:0] w_bx;
    logic [w-1:0] w_c;

    assign w_bx   = i_b ^ {w{i_sub}};
    assign w_c[0] = i_sub;

    genvar gi;
    generate
        for (gi = 0; gi < w - 1; gi++) begin : g_cell
            fac u_fac (
                .i_a   (i_a[gi]),
                .i_b   (w_bx[gi]),
                .i_cin (w_c[gi]),
                .o_s   (o_s[gi]),
                .o_cout(w_c[gi+1])
            );
        end
    endgenerate

    // Top bit carries the sign of the difference; its carry-out is never needed.
    assign o_s[w-1] = i_a[w-1] ^ w_bx[w-1] ^ w_c[w-1];
endmodule

// File: rtl/restoring_divider.sv
// Sequential unsigned restoring divider: one quotient bit per clock, start/done
// handshake, divide-by-zero reported with an all-ones quotient and r = x.
module restoring_divider
    import restoring_divider_pkg::*;
#(
    parameter int w = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [w-1:0] x,
    input  logic [w-1:0] y,
    output logic         busy,
    output logic         done,
    output logic [w-1:0] q,
    output logic [w-1:0] r,
    output logic         dbz
);
    localparam int CW = $clog2(w + 1);

    state_t         r_state;
    state_t         w_next_state;
    // Partial remainder stays below the divisor, so its (w+1)th bit is always zero.
    logic [w-1:0]   r_a;
    logic [w-1:0]   r_qreg;
    logic [w:0]     r_m;
    logic [CW-1:0]  r_count;
    logic [w-1:0]   r_q;
    logic [w-1:0]   r_r;
    logic           r_dbz;

    logic [w:0]     w_s;
    logic [w:0]     w_t;
    logic [w-1:0]   w_a_nxt;
    logic [w-1:0]   w_q_nxt;
    logic           w_last;

    assign w_s    = {r_a, r_qreg[w-1]};
    assign w_last = (r_count == CW'(1));

    adder_subtractor #(
        .w(w + 1)
    ) u_addsub (
        .i_a  (w_s),
        .i_b  (r_m),
        .i_sub(1'b1),
        .o_s  (w_t)
    );

    // Restore step: keep the difference when non-negative, else keep the shifted value.
    always_comb begin
        w_a_nxt = w_s[w-1:0];
        w_q_nxt = {r_qreg[w-2:0], 1'b0};
        if (w_t[w] == 1'b0) begin
            w_a_nxt = w_t[w-1:0];
            w_q_nxt = {r_qreg[w-2:0], 1'b1};
        end else begin
            w_a_nxt = w_s[w-1:0];
            w_q_nxt = {r_qreg[w-2:0], 1'b0};
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; start is honoured only when idle or completing.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE, DONE: begin
                if (start) begin
                    w_next_state = (y == {w{1'b0}}) ? DONE : RUN;
                end else begin
                    w_next_state = IDLE;
                end
            end
            RUN: begin
                if (w_last) begin
                    w_next_state = DONE;
                end else begin
                    w_next_state = RUN;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Datapath registers: operand capture, iteration, and result update.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a     <= {w{1'b0}};
            r_qreg  <= {w{1'b0}};
            r_m     <= {(w + 1){1'b0}};
            r_count <= {CW{1'b0}};
            r_q     <= {w{1'b0}};
            r_r     <= {w{1'b0}};
            r_dbz   <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (start && (y == {w{1'b0}})) begin
                        r_q   <= DBZ_QUOTIENT_ALL[w-1:0];
                        r_r   <= x;
                        r_dbz <= 1'b1;
                    end else if (start) begin
                        r_a     <= {w{1'b0}};
                        r_qreg  <= x;
                        r_m     <= {1'b0, y};
                        r_count <= CW'(w);
                    end
                end
                RUN: begin
                    r_a     <= w_a_nxt;
                    r_qreg  <= w_q_nxt;
                    r_count <= r_count - CW'(1);
                    if (w_last) begin
                        r_q   <= w_q_nxt;
                        r_r   <= w_a_nxt;
                        r_dbz <= 1'b0;
                    end
                end
                default: begin
                    r_count <= {CW{1'b0}};
                end
            endcase
        end
    end

    // Handshake outputs decode directly from the state register.
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (r_state)
            RUN:     busy = 1'b1;
            DONE:    done = 1'b1;
            default: begin
                busy = 1'b0;
                done = 1'b0;
            end
        endcase
    end

    assign q   = r_q;
    assign r   = r_r;
    assign dbz = r_dbz;

endmodule

// File: tb/tb_restoring_divider.sv
// Directed bench for restoring_divider: an 8-bit instance for the scenario
// tests and a 3-bit instance swept over every operand pair.
module tb_restoring_divider;
    localparam int W  = 8;
    localparam int WS = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          start;
    logic [W-1:0]  x, y, q, r;
    logic          busy, done, dbz;

    logic          s_start;
    logic [WS-1:0] s_x, s_y, s_q, s_r;
    logic          s_busy, s_done, s_dbz;

    int n_vec = 0;
    int n_err = 0;

    restoring_divider #(.w(W)) dut (
        .clk(clk), .rst(rst), .start(start), .x(x), .y(y),
        .busy(busy), .done(done), .q(q), .r(r), .dbz(dbz)
    );

    restoring_divider #(.w(WS)) dut_small (
        .clk(clk), .rst(rst), .start(s_start), .x(s_x), .y(s_y),
        .busy(s_busy), .done(s_done), .q(s_q), .r(s_r), .dbz(s_dbz)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one operation for a single accepting edge, then drop start.
    task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b);
        start = 1'b1;
        x     = a;
        y     = b;
        step();
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; x = 8'd0; y = 8'd0;
        s_start = 1'b0; s_x = 3'd0; s_y = 3'd0;
        step(); step();
        rst = 1'b0;
        n_vec++;
        if (busy !== 1'b0 || done !== 1'b0 || q !== 8'd0 || r !== 8'd0 || dbz !== 1'b0) begin
            $display("FAIL reset_outputs: busy=%0b done=%0b q=%0d r=%0d dbz=%0b, want 0 0 0 0 0",
                     busy, done, q, r, dbz);
            n_err++;
        end
        step();
        n_vec++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            $display("FAIL idle_no_start: busy=%0b done=%0b, want 0 0", busy, done);
            n_err++;
        end
    endtask

    task automatic test_basic();
        launch(8'd100, 8'd7);
        for (int i = 0; i < W; i++) begin
            n_vec++;
            if (busy !== 1'b1 || done !== 1'b0) begin
                $display("FAIL basic_busy cycle %0d: busy=%0b done=%0b, want 1 0", i, busy, done);
                n_err++;
            end
            step();
        end
        n_vec++;
        if (done !== 1'b1 || busy !== 1'b0 || q !== 8'd14 || r !== 8'd2 || dbz !== 1'b0) begin
            $display("FAIL basic_result: done=%0b busy=%0b q=%0d r=%0d dbz=%0b, want 1 0 14 2 0",
                     done, busy, q, r, dbz);
            n_err++;
        end
        step();
        n_vec++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            $display("FAIL basic_single_pulse: done=%0b busy=%0b, want 0 0", done, busy);
            n_err++;
        end
    endtask

    task automatic test_hold();
        launch(8'd255, 8'd1);
        repeat (W) step();
        n_vec++;
        if (done !== 1'b1 || q !== 8'd255 || r !== 8'd0) begin
            $display("FAIL max_div_one: done=%0b q=%0d r=%0d, want 1 255 0", done, q, r);
            n_err++;
        end
        x = 8'd33; y = 8'd4;
        repeat (5) step();
        n_vec++;
        if (done !== 1'b0 || q !== 8'd255 || r !== 8'd0) begin
            $display("FAIL hold_idle: done=%0b q=%0d r=%0d, want 0 255 0", done, q, r);
            n_err++;
        end
        launch(8'd5, 8'd9);
        repeat (W) step();
        n_vec++;
        if (done !== 1'b1 || q !== 8'd0 || r !== 8'd5 || dbz !== 1'b0) begin
            $display("FAIL small_dividend: done=%0b q=%0d r=%0d dbz=%0b, want 1 0 5 0", done, q, r, dbz);
            n_err++;
        end
    endtask

    task automatic test_div_by_zero();
        launch(8'd42, 8'd0);
        n_vec++;
        if (done !== 1'b1 || busy !== 1'b0 || dbz !== 1'b1 || q !== 8'd255 || r !== 8'd42) begin
            $display("FAIL dbz_result: done=%0b busy=%0b dbz=%0b q=%0d r=%0d, want 1 0 1 255 42",
                     done, busy, dbz, q, r);
            n_err++;
        end
        step();
        n_vec++;
        if (done !== 1'b0 || dbz !== 1'b1 || q !== 8'd255) begin
            $display("FAIL dbz_hold: done=%0b dbz=%0b q=%0d, want 0 1 255", done, dbz, q);
            n_err++;
        end
        launch(8'd9, 8'd3);
        repeat (W) step();
        n_vec++;
        if (done !== 1'b1 || q !== 8'd3 || r !== 8'd0 || dbz !== 1'b0) begin
            $display("FAIL dbz_clear: done=%0b q=%0d r=%0d dbz=%0b, want 1 3 0 0", done, q, r, dbz);
            n_err++;
        end
    endtask

    task automatic test_reset_mid_op();
        int seen_done;
        launch(8'd200, 8'd3);
        repeat (3) step();
        n_vec++;
        if (busy !== 1'b1) begin
            $display("FAIL midop_running: busy=%0b, want 1", busy);
            n_err++;
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_vec++;
        if (busy !== 1'b0 || done !== 1'b0 || q !== 8'd0 || r !== 8'd0 || dbz !== 1'b0) begin
            $display("FAIL midop_reset: busy=%0b done=%0b q=%0d r=%0d dbz=%0b, want 0 0 0 0 0",
                     busy, done, q, r, dbz);
            n_err++;
        end
        seen_done = 0;
        for (int i = 0; i < 12; i++) begin
            if (done === 1'b1 || busy === 1'b1) seen_done++;
            step();
        end
        n_vec++;
        if (seen_done != 0) begin
            $display("FAIL midop_no_done: active cycles=%0d, want 0", seen_done);
            n_err++;
        end
        launch(8'd200, 8'd3);
        repeat (W) step();
        n_vec++;
        if (done !== 1'b1 || q !== 8'd66 || r !== 8'd2) begin
            $display("FAIL midop_rerun: done=%0b q=%0d r=%0d, want 1 66 2", done, q, r);
            n_err++;
        end
    endtask

    task automatic test_back_to_back();
        start = 1'b1; x = 8'd50; y = 8'd6;
        step();
        for (int i = 0; i < W; i++) begin
            x = 8'(i * 37 + 11);
            y = 8'(i + 1);
            n_vec++;
            if (busy !== 1'b1 || done !== 1'b0 || q !== 8'd66) begin
                $display("FAIL b2b_ignore_start cycle %0d: busy=%0b done=%0b q=%0d, want 1 0 66",
                         i, busy, done, q);
                n_err++;
            end
            step();
        end
        n_vec++;
        if (done !== 1'b1 || q !== 8'd8 || r !== 8'd2) begin
            $display("FAIL b2b_first: done=%0b q=%0d r=%0d, want 1 8 2", done, q, r);
            n_err++;
        end
        x = 8'd77; y = 8'd10;
        step();
        start = 1'b0;
        n_vec++;
        if (busy !== 1'b1 || done !== 1'b0 || q !== 8'd8) begin
            $display("FAIL b2b_relaunch: busy=%0b done=%0b q=%0d, want 1 0 8", busy, done, q);
            n_err++;
        end
        repeat (W - 1) step();
        n_vec++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            $display("FAIL b2b_spacing: busy=%0b done=%0b, want 1 0", busy, done);
            n_err++;
        end
        step();
        n_vec++;
        if (done !== 1'b1 || q !== 8'd7 || r !== 8'd7) begin
            $display("FAIL b2b_second: done=%0b q=%0d r=%0d, want 1 7 7", done, q, r);
            n_err++;
        end
    endtask

    task automatic test_exhaustive_w3();
        int cyc;
        int exp_lat;
        logic [WS-1:0] eq, er;
        for (int xi = 0; xi < 8; xi++) begin
            for (int yi = 0; yi < 8; yi++) begin
                s_start = 1'b1;
                s_x = 3'(xi);
                s_y = 3'(yi);
                step();
                s_start = 1'b0;
                cyc = 0;
                while (s_done !== 1'b1 && cyc < 10) begin
                    step();
                    cyc++;
                end
                exp_lat = (yi == 0) ? 0 : WS;
                eq = (yi == 0) ? 3'd7 : 3'(xi / yi);
                er = (yi == 0) ? 3'(xi) : 3'(xi % yi);
                n_vec++;
                if (s_done !== 1'b1 || cyc != exp_lat || s_q !== eq || s_r !== er ||
                    s_dbz !== (yi == 0)) begin
                    $display("FAIL w3 %0d/%0d: done=%0b lat=%0d q=%0d r=%0d dbz=%0b, want 1 %0d %0d %0d %0b",
                             xi, yi, s_done, cyc, s_q, s_r, s_dbz, exp_lat, eq, er, (yi == 0));
                    n_err++;
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_hold();
        test_div_by_zero();
        test_reset_mid_op();
        test_back_to_back();
        test_exhaustive_w3();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
